// File: rtl/hazard_tracker_pkg.sv
// Shared codes and entry layouts for the pipeline hazard tracker.
package hazard_tracker_pkg;

    // Stage at which an operand is first needed / a result first exists.
    localparam logic [1:0] STAGE_DECODE  = 2'd0;
    localparam logic [1:0] STAGE_EXECUTE = 2'd1;
    localparam logic [1:0] STAGE_MEM     = 2'd2;
    localparam logic [1:0] STAGE_MAX     = 2'd3;

    // Forwarding-mux select codes.
    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    // Pipeline positions of the tracked writers. They equal the matching
    // FWD_* code, which the selector relies on.
    localparam logic [1:0] POS_E = 2'd1;
    localparam logic [1:0] POS_M = 2'd2;
    localparam logic [1:0] POS_W = 2'd3;

    typedef struct packed {
        logic [4:0] waddr;
        logic [1:0] wstage;
        logic [4:0] raddr0;
        logic [4:0] raddr1;
    } e_entry_t;

    typedef struct packed {
        logic [4:0] waddr;
        logic [1:0] wstage;
        logic [4:0] raddr1;
    } m_entry_t;

    typedef struct packed {
        logic [4:0] waddr;
        logic [1:0] wstage;
    } w_entry_t;

    // Register $0 is never a dependency.
    function automatic logic addr_hit(input logic [4:0] r, input logic [4:0] w);
        return (r != 5'd0) && (w == r);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Nearest-producer selector for one operand consumption point. Entry 0 is
// the youngest writer and has the highest priority.
module hazard_fwd_sel
    import hazard_tracker_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [4:0]        raddr,
    input  logic [1:0]        need_stage,
    input  logic [N-1:0][1:0] pos,
    input  logic [N-1:0][4:0] waddr,
    input  logic [N-1:0][1:0] wstage,
    output logic              match,
    output logic [1:0]        sel,
    output logic              ready
);

    logic [N-1:0] hit_s;
    logic [1:0]   hit_pos_s;
    logic [1:0]   hit_stage_s;
    logic [2:0]   due_s;

    // Pick the youngest matching writer and derive forward code and readiness.
    always_comb begin
        match       = 1'b0;
        hit_pos_s   = 2'd0;
        hit_stage_s = 2'd0;
        sel         = FWD_NONE;
        ready       = 1'b1;
        for (int i = 0; i < N; i++) begin
            hit_s[i] = addr_hit(raddr, waddr[i]);
            if (hit_s[i] && !match) begin
                match       = 1'b1;
                hit_pos_s   = pos[i];
                hit_stage_s = wstage[i];
            end else begin
                match = match;
            end
        end
        // The consumer reaches its need point p+need stages after the
        // writer's current position; the value must exist strictly before.
        due_s = {1'b0, hit_pos_s} + {1'b0, need_stage};
        if (match) begin
            // A result produced at stage s is on a bypass bus once the
            // writer has moved past s, i.e. s < position.
            sel   = (hit_stage_s < hit_pos_s) ? hit_pos_s : FWD_NONE;
            ready = (due_s > {1'b0, hit_stage_s});
        end else begin
            sel   = FWD_NONE;
            ready = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks writers in E/M/W, raises the pipeline stall and drives every
// forwarding-mux select. Owns no datapath.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       d_read_addr0,
    input  logic [4:0]       d_read_addr1,
    input  logic [1:0]       d_read_stage0,
    input  logic [1:0]       d_read_stage1,
    input  logic [4:0]       d_write_addr,
    input  logic [1:0]       d_write_stage,
    output logic             stall,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [1:0]       fwd_m_rt,
    output logic [CNT_W-1:0] stall_count
);

    e_entry_t         e_q, e_d;
    m_entry_t         m_q, m_d;
    w_entry_t         w_q, w_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic       d_rs_match_s, d_rs_ready_s, d_rt_match_s, d_rt_ready_s;
    logic       e_rs_match_s, e_rs_ready_s, e_rt_match_s, e_rt_ready_s;
    logic       m_rt_match_s, m_rt_ready_s;
    logic [1:0] d_rs_sel_s, d_rt_sel_s, e_rs_sel_s, e_rt_sel_s, m_rt_sel_s;

    // D-stage operands see all three writers; they also decide the stall.
    hazard_fwd_sel #(.N(3)) u_sel_d_rs (
        .raddr(d_read_addr0), .need_stage(d_read_stage0),
        .pos({POS_W, POS_M, POS_E}),
        .waddr({w_q.waddr, m_q.waddr, e_q.waddr}),
        .wstage({w_q.wstage, m_q.wstage, e_q.wstage}),
        .match(d_rs_match_s), .sel(d_rs_sel_s), .ready(d_rs_ready_s)
    );

    hazard_fwd_sel #(.N(3)) u_sel_d_rt (
        .raddr(d_read_addr1), .need_stage(d_read_stage1),
        .pos({POS_W, POS_M, POS_E}),
        .waddr({w_q.waddr, m_q.waddr, e_q.waddr}),
        .wstage({w_q.wstage, m_q.wstage, e_q.wstage}),
        .match(d_rt_match_s), .sel(d_rt_sel_s), .ready(d_rt_ready_s)
    );

    // Downstream points never stall (the D check already guaranteed
    // availability), so their need stage is tied to STAGE_MAX.
    hazard_fwd_sel #(.N(2)) u_sel_e_rs (
        .raddr(e_q.raddr0), .need_stage(STAGE_MAX),
        .pos({POS_W, POS_M}),
        .waddr({w_q.waddr, m_q.waddr}),
        .wstage({w_q.wstage, m_q.wstage}),
        .match(e_rs_match_s), .sel(e_rs_sel_s), .ready(e_rs_ready_s)
    );

    hazard_fwd_sel #(.N(2)) u_sel_e_rt (
        .raddr(e_q.raddr1), .need_stage(STAGE_MAX),
        .pos({POS_W, POS_M}),
        .waddr({w_q.waddr, m_q.waddr}),
        .wstage({w_q.wstage, m_q.wstage}),
        .match(e_rt_match_s), .sel(e_rt_sel_s), .ready(e_rt_ready_s)
    );

    hazard_fwd_sel #(.N(1)) u_sel_m_rt (
        .raddr(m_q.raddr1), .need_stage(STAGE_MAX),
        .pos(POS_W),
        .waddr(w_q.waddr),
        .wstage(w_q.wstage),
        .match(m_rt_match_s), .sel(m_rt_sel_s), .ready(m_rt_ready_s)
    );

    // Stall on the worse operand; selects pass only for timely matches.
    always_comb begin
        stall    = ~d_rs_ready_s | ~d_rt_ready_s;
        fwd_d_rs = (d_rs_match_s && d_rs_ready_s) ? d_rs_sel_s : FWD_NONE;
        fwd_d_rt = (d_rt_match_s && d_rt_ready_s) ? d_rt_sel_s : FWD_NONE;
        fwd_e_rs = (e_rs_match_s && e_rs_ready_s) ? e_rs_sel_s : FWD_NONE;
        fwd_e_rt = (e_rt_match_s && e_rt_ready_s) ? e_rt_sel_s : FWD_NONE;
        fwd_m_rt = (m_rt_match_s && m_rt_ready_s) ? m_rt_sel_s : FWD_NONE;
        stall_count = stall_count_q;
    end

    // Advance the writer pipeline; a stalled D inserts a bubble into E.
    always_comb begin
        e_d = '0;
        if (stall) begin
            e_d = '0;
        end else begin
            e_d.waddr  = d_write_addr;
            e_d.wstage = d_write_stage;
            e_d.raddr0 = d_read_addr0;
            e_d.raddr1 = d_read_addr1;
        end
        m_d.waddr  = e_q.waddr;
        m_d.wstage = e_q.wstage;
        m_d.raddr1 = e_q.raddr1;
        w_d.waddr  = m_q.waddr;
        w_d.wstage = m_q.wstage;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q           <= '0;
            m_q           <= '0;
            w_q           <= '0;
            stall_count_q <= '0;
        end else begin
            e_q           <= e_d;
            m_q           <= m_d;
            w_q           <= w_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: stall decisions, forward selects,
// bubble insertion, stall counter and asynchronous reset.
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  d_read_addr0, d_read_addr1, d_write_addr;
    logic [1:0]  d_read_stage0, d_read_stage1, d_write_stage;
    logic        stall;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
    logic [31:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    hazard_tracker #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .d_read_addr0(d_read_addr0), .d_read_addr1(d_read_addr1),
        .d_read_stage0(d_read_stage0), .d_read_stage1(d_read_stage1),
        .d_write_addr(d_write_addr), .d_write_stage(d_write_stage),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ra0, input logic [1:0] rs0,
                         input logic [4:0] ra1, input logic [1:0] rs1,
                         input logic [4:0] wa, input logic [1:0] ws);
        d_read_addr0  = ra0;
        d_read_stage0 = rs0;
        d_read_addr1  = ra1;
        d_read_stage1 = rs1;
        d_write_addr  = wa;
        d_write_stage = ws;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_count", stall_count, 32'd0);
        chk("reset_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
        chk("reset_fwd_m_rt", 32'(fwd_m_rt), 32'd0);
        #11;
        reset_n = 1'b1;
        tick();

        // addu $1 (ready after E) then a reader needing $1 in E.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd1);
        tick();
        drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd4, 2'd1);
        @(negedge clk);
        chk("alu_no_stall", 32'(stall), 32'd0);
        chk("alu_fwd_d_rs_none", 32'(fwd_d_rs), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("alu_fwd_e_rs_m", 32'(fwd_e_rs), 32'd2);

        // lw $1 then addu reading $1 in E: one stall, then forward from W.
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2);
        tick();
        drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd3, 2'd1);
        @(negedge clk);
        chk("lw_use_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("lw_use_stall_end", 32'(stall), 32'd0);
        chk("lw_use_count", stall_count, 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("lw_use_fwd_e_rs_w", 32'(fwd_e_rs), 32'd3);

        // lw $1 then beq comparing $1 in D: two stalls, two bubbles.
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2);
        tick();
        drive(5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
        @(negedge clk);
        chk("lw_beq_stall1", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("lw_beq_bubble1", 32'(dut.e_q), 32'd0);
        chk("lw_beq_stall2", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("lw_beq_bubble2", 32'(dut.e_q), 32'd0);
        chk("lw_beq_stall_end", 32'(stall), 32'd0);
        chk("lw_beq_fwd_d_rs_w", 32'(fwd_d_rs), 32'd3);
        chk("lw_beq_count", stall_count, 32'd3);
        tick();

        // jal writes $31 in D; jr reads it in D straight from E.
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0);
        tick();
        drive(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
        @(negedge clk);
        chk("jal_jr_no_stall", 32'(stall), 32'd0);
        chk("jal_jr_fwd_d_rs_e", 32'(fwd_d_rs), 32'd1);
        tick();

        // addu $1 in M, lw $1 in E: the younger lw governs.
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd1);
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2);
        tick();
        drive(5'd0, 2'd3, 5'd1, 2'd1, 5'd5, 2'd1);
        @(negedge clk);
        chk("nearest_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("nearest_stall_end", 32'(stall), 32'd0);
        chk("nearest_fwd_d_rt_none", 32'(fwd_d_rt), 32'd0);
        tick();

        // Same shape with $0 destinations and $0 reads: nothing matches.
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1);
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
        tick();
        drive(5'd0, 2'd1, 5'd0, 2'd0, 5'd0, 2'd1);
        @(negedge clk);
        chk("zero_no_stall", 32'(stall), 32'd0);
        chk("zero_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
        chk("zero_fwd_d_rt", 32'(fwd_d_rt), 32'd0);
        chk("zero_fwd_e_rs", 32'(fwd_e_rs), 32'd0);
        chk("zero_fwd_e_rt", 32'(fwd_e_rt), 32'd0);
        chk("zero_fwd_m_rt", 32'(fwd_m_rt), 32'd0);
        tick();

        // addu $2 then sw storing $2: E then M forwarding of store data.
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1);
        tick();
        drive(5'd0, 2'd3, 5'd2, 2'd2, 5'd0, 2'd0);
        @(negedge clk);
        chk("sw_no_stall", 32'(stall), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("sw_fwd_e_rt_m", 32'(fwd_e_rt), 32'd2);
        tick();
        @(negedge clk);
        chk("sw_fwd_m_rt_w", 32'(fwd_m_rt), 32'd3);

        // Reset asserted in the middle of a load-use stall.
        flush();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2);
        tick();
        drive(5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
        @(negedge clk);
        chk("rst_pre_stall", 32'(stall), 32'd1);
        chk("rst_pre_count", stall_count, 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_count", stall_count, 32'd0);
        chk("rst_mid_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_post_stall", 32'(stall), 32'd0);
        chk("rst_post_count", stall_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Consumes the per-instruction hazard descriptors that the decode stage produces for the instruction in D: read addresses with need-stage, and write address with ready-stage.
- Tracks in-flight writers in E/M/W, decides stall, and emits forwarding-select codes for every operand consumption point.
- Sits beside the 5-stage pipeline registers. It owns no datapath; it only steers the forwarding muxes and the F/D freeze / E bubble.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- d_read_addr0  in  5  rs address of the instruction in D
- d_read_addr1  in  5  rt address of the instruction in D
- d_read_stage0  in  2  stage at which rs is first needed (STAGE_MAX = unused)
- d_read_stage1  in  2  stage at which rt is first needed
- d_write_addr  in  5  destination register (0 = no write)
- d_write_stage  in  2  stage at whose end the result exists (DECODE / EXECUTE / MEM)
- stall  out  1  freeze PC and F/D, bubble E
- fwd_d_rs, fwd_d_rt  out  2  forward select for D-stage compare/jump operands
- fwd_e_rs, fwd_e_rt  out  2  forward select for ALU operands in E
- fwd_m_rt  out  2  forward select for store data in M
- stall_count  out  CNT_W  number of cycles with stall=1, saturating at all-ones

Behaviour:
- Stage codes: STAGE_DECODE=0, STAGE_EXECUTE=1, STAGE_MEM=2, STAGE_MAX=3.
- Forward codes: FWD_NONE=0 (GRF or pipeline value), FWD_E=1, FWD_M=2, FWD_W=3. Positions: E=1, M=2, W=3.
- State, one entry per stage:
  - E entry: waddr, wstage, raddr0, raddr1.
  - M entry: waddr, wstage, raddr1.
  - W entry: waddr, wstage.
- Reset (async, reset_n=0): all waddr/raddr=0, wstage=0, stall_count=0. All outputs go to 0 immediately, since empty entries cannot match.
- Each posedge: W<=M, M<=E.
  - If stall=0: E<=D descriptors.
  - If stall=1: E<=bubble (all fields 0).
- Match rule: an entry matches operand address r only if r!=0 and waddr==r. Only the nearest match counts, priority E over M over W. An older match behind a younger one is ignored.
- Stall (combinational): for each D operand with read_stage!=STAGE_MAX, take the nearest match at position p with ready stage s. Stall if p + read_stage <= s. stall = OR over both operands.
- D select, from the nearest match:
  - E with wstage=0 -> FWD_E.
  - M with wstage<=1 -> FWD_M.
  - W -> FWD_W.
  - Otherwise FWD_NONE.
  - Meaningful only when stall=0.
- E select: same rule over M and W for E.raddr0/raddr1, M-entry priority.
- M select: fwd_m_rt=FWD_W when the W entry matches M.raddr1, else FWD_NONE.
- Latency: all selects and stall are combinational from the current state and D inputs. There is no added cycle.
- stall_count increments on each posedge where stall=1, and holds at max.
- Simultaneous rs and rt hazards produce a single stall. The stall length is set by the worse operand.
- Reset asserted mid-stall: entries are cleared, stall drops asynchronously, and the counter clears.

Decomposition:
- Stage codes and FWD_* codes belong in the shared def.v include, next to the existing STAGE_* defines.
- One sub-module: hazard_fwd_sel. It is the combinational nearest-match priority selector. Inputs are the operand address plus a list of (position, waddr, wstage) entries. Outputs are the match flag, the select code and the ready flag. It is instantiated once per consumption point.

Test Plan:
- addu $1 in E (wstage=1); D reads rs=1 with stage=EXECUTE -> stall=0. Next cycle fwd_e_rs=FWD_M.
- lw $1 in E (wstage=2); D addu reads rs=1 at EXECUTE:
  - Required: stall=1 for exactly 1 cycle, then fwd_e_rs=FWD_W.
  - Required: stall_count=1.
- lw $1 in E; D beq reads rs=1 at DECODE:
  - Required: stall=1 for 2 cycles, then fwd_d_rs=FWD_W.
  - Required: E receives 2 bubbles.
- jal (waddr=31, wstage=0) in E; D jr reads rs=31 -> stall=0, fwd_d_rs=FWD_E.
- Nearest producer: addu $1 in M and lw $1 in E; D reads rs=1 at EXECUTE -> stall=1 (the lw governs). With $0 destinations -> stall=0 and all selects FWD_NONE.
- sw rt=2 in E, addu $2 in M: after one posedge, fwd_m_rt=FWD_W. Pull reset_n low mid-stall -> stall=0 and stall_count=0 immediately.
